// File: rtl/ofmap_store_if.sv
// ofmap_store_if: bundles the ofmap store controller's control, capture and GLB write signals.
//   master : token engine / GLB side (drives start, layer type, base, PE data, stall)
//   slave  : ofmap_store_controller (drives WEB, address, write data, busy, done)
// Layer-type encodings are shared with the weight-load path.

`ifndef POINTWISE
`define POINTWISE 2'd0
`endif
`ifndef DEPTHWISE
`define DEPTHWISE 2'd1
`endif
`ifndef STANDARD
`define STANDARD 2'd2
`endif
`ifndef LINEAR
`define LINEAR 2'd3
`endif

interface ofmap_store_if #(
    parameter int unsigned NUM_COL = 32
);
    logic                   store_start_i;
    logic [1:0]             layer_type_i;
    logic [31:0]            ofmap_GLB_base_addr_i;
    logic [NUM_COL*8-1:0]   pe_out_data_i;
    logic                   glb_stall_i;
    logic [3:0]             ofmap_store_WEB_o;
    logic [31:0]            ofmap_addr_o;
    logic [31:0]            ofmap_wdata_o;
    logic                   store_busy_o;
    logic                   store_done_o;

    modport master (
        output store_start_i, layer_type_i, ofmap_GLB_base_addr_i, pe_out_data_i, glb_stall_i,
        input  ofmap_store_WEB_o, ofmap_addr_o, ofmap_wdata_o, store_busy_o, store_done_o
    );

    modport slave (
        input  store_start_i, layer_type_i, ofmap_GLB_base_addr_i, pe_out_data_i, glb_stall_i,
        output ofmap_store_WEB_o, ofmap_addr_o, ofmap_wdata_o, store_busy_o, store_done_o
    );
endinterface

// File: rtl/ofmap_store_controller.sv
// ofmap_store_controller: writes one row of PE output bytes to the GLB as packed 32-bit
// word writes starting at a possibly unaligned byte address, with per-lane write enables
// on partial first/last words.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ofmap_store_if.slave (start/layer/base/PE data/stall in; WEB/addr/wdata/busy/done out)
// Build option: define OFMAP_RELU_EN to clamp negative captured bytes to 0x00 before packing.

`ifndef POINTWISE
`define POINTWISE 2'd0
`endif
`ifndef DEPTHWISE
`define DEPTHWISE 2'd1
`endif
`ifndef STANDARD
`define STANDARD 2'd2
`endif
`ifndef LINEAR
`define LINEAR 2'd3
`endif

module ofmap_store_controller #(
    parameter int unsigned NUM_COL = 32,
    parameter int unsigned DATA_W  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    ofmap_store_if.slave  bus
);
    localparam int unsigned BUF_W  = NUM_COL * DATA_W;
    localparam int unsigned CNT_W  = 6;   // element count up to 32
    localparam int unsigned WCNT_W = 4;   // word count up to 9

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    typedef struct packed {
        logic [3:0]  web;
        logic [31:0] data;
    } word_t;

    state_t              state;
    logic [BUF_W-1:0]    buf_q;
    logic [1:0]          off_q;
    logic [CNT_W-1:0]    n_q;
    logic [WCNT_W-1:0]   k_q;
    logic [WCNT_W-1:0]   w_q;
    logic [3:0]          web_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic                busy_q;
    logic                done_q;

    logic [CNT_W-1:0]    n_c;
    logic [WCNT_W-1:0]   w_c;
    logic [WCNT_W-1:0]   next_k_c;
    logic [BUF_W-1:0]    capt_c;
    word_t               first_word_c;
    word_t               next_word_c;

    // Build lane enables and data for word k: lane l carries byte 4k + l - offset.
    function automatic word_t pack_word(input logic [BUF_W-1:0] data,
                                        input logic [1:0] off,
                                        input logic [CNT_W-1:0] n,
                                        input logic [WCNT_W-1:0] k);
        word_t w;
        int    b;
        w = '0;
        for (int l = 0; l < 4; l++) begin
            b = 4 * int'(k) + l - int'(off);
            if (b >= 0 && b < int'(n)) begin
                w.web[l]         = 1'b1;
                w.data[8*l +: 8] = data[8*b +: 8];
            end
        end
        return w;
    endfunction

    // Optional signed clamp of each captured byte.
    function automatic logic [BUF_W-1:0] condition_bytes(input logic [BUF_W-1:0] raw);
        logic [BUF_W-1:0] out;
        out = raw;
`ifdef OFMAP_RELU_EN
        for (int c = 0; c < int'(NUM_COL); c++) begin
            if (raw[8*c + 7]) out[8*c +: 8] = 8'h00;
        end
`endif
        return out;
    endfunction

    // Element count from layer type.
    always_comb begin
        n_c = '0;
        case (bus.layer_type_i)
            `POINTWISE: n_c = CNT_W'(32);
            `DEPTHWISE: n_c = CNT_W'(10);
            `STANDARD:  n_c = CNT_W'(10);
            `LINEAR:    n_c = CNT_W'(32);
            default:    n_c = '0;
        endcase
    end

    assign w_c          = WCNT_W'((32'(bus.ofmap_GLB_base_addr_i[1:0]) + 32'(n_c) + 32'd3) >> 2);
    assign capt_c       = condition_bytes(bus.pe_out_data_i);
    assign next_k_c     = k_q + WCNT_W'(1);
    assign first_word_c = pack_word(capt_c, bus.ofmap_GLB_base_addr_i[1:0], n_c, '0);
    assign next_word_c  = pack_word(buf_q, off_q, n_q, next_k_c);

    // Store sequencer with registered GLB outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            buf_q   <= '0;
            off_q   <= '0;
            n_q     <= '0;
            k_q     <= '0;
            w_q     <= '0;
            web_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.store_start_i) begin
                        busy_q <= 1'b1;
                        if (n_c != '0) begin
                            state   <= S_WRITE;
                            buf_q   <= capt_c;
                            off_q   <= bus.ofmap_GLB_base_addr_i[1:0];
                            n_q     <= n_c;
                            w_q     <= w_c;
                            k_q     <= '0;
                            addr_q  <= {bus.ofmap_GLB_base_addr_i[31:2], 2'b00};
                            web_q   <= first_word_c.web;
                            wdata_q <= first_word_c.data;
                        end else begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    // Outputs hold while the GLB stalls.
                    if (!bus.glb_stall_i) begin
                        if (next_k_c == w_q) begin
                            state   <= S_DONE;
                            web_q   <= '0;
                            addr_q  <= '0;
                            wdata_q <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            k_q     <= next_k_c;
                            addr_q  <= addr_q + 32'd4;
                            web_q   <= next_word_c.web;
                            wdata_q <= next_word_c.data;
                        end
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ofmap_store_WEB_o = web_q;
    assign bus.ofmap_addr_o      = addr_q;
    assign bus.ofmap_wdata_o     = wdata_q;
    assign bus.store_busy_o      = busy_q;
    assign bus.store_done_o      = done_q;

endmodule

// File: doc/ofmap_store_controller.md
# ofmap_store_controller

Writes one row of PE-array output bytes back to the GLB as packed 32-bit word writes. It starts from a byte base address that may be unaligned and issues per-lane write enables for partial first and last words. It sits between the PE array output columns and the GLB write port, and is sequenced by the token engine. It mirrors the weight-load path: byte-addressed GLB traffic, with the same layer-type encoding from `define.svh`.

## Interface
Parameters:
- `NUM_COL`, 32, number of PE output columns (bytes captured per store).
- `DATA_W`, 8, bits per output element; fixed at one byte.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `store_start_i` input 1: one-cycle start pulse. Honoured only in IDLE.
- `layer_type_i` input 2: `POINTWISE`/`DEPTHWISE`/`STANDARD`/`LINEAR` macros. Sampled on start.
- `ofmap_GLB_base_addr_i` input 32: byte address of output byte 0. Sampled on start.
- `pe_out_data_i` input NUM_COL×8: column c output byte. Sampled on start.
- `glb_stall_i` input 1: GLB cannot accept a write this cycle.
- `ofmap_store_WEB_o` output 4: per-lane write enable; 1 = write, lane0 = bits[7:0].
- `ofmap_addr_o` output 32: word-aligned byte address; bits [1:0] are always 0.
- `ofmap_wdata_o` output 32: packed write data; disabled lanes are 0.
- `store_busy_o` output 1: high from the cycle after start through DONE.
- `store_done_o` output 1: one-cycle completion pulse.

## Operation
Element count N is set by the sampled layer type:
- `POINTWISE`: 32
- `DEPTHWISE`: 10
- `STANDARD`: 10
- `LINEAR`: 32
- any other value: 0

States: IDLE, WRITE, DONE.
- IDLE → WRITE on `store_start_i` when N>0. On the same edge, latch data, base address and N.
- IDLE → DONE on `store_start_i` when N=0. No write is issued.
- WRITE → DONE when the last word is accepted.
- DONE → IDLE unconditionally after one cycle.

Packing:
- offset = base[1:0]; word count W = ceil((offset+N)/4), computed with 32-bit width.
- Word k (k=0..W-1) is written at address (base & ~3) + 4k.
- Lane l of word k carries byte index b = 4k + l − offset. The lane is enabled if 0 ≤ b < N; otherwise its WEB bit and data are 0.

Handshake:
- A write is accepted in any WRITE cycle with `glb_stall_i`=0.
- While stalled, the address, data and WEB outputs are held unchanged.
- `store_start_i` in WRITE or DONE is ignored and does not restart the store.
- The latched buffer is unaffected by `pe_out_data_i` changing after start.

## Timing
- Reset values: all outputs 0, FSM in IDLE, buffer cleared. Reset mid-store aborts immediately, and no done pulse is issued.
- Start sampled at edge T. Word 0 appears on the outputs in cycle T+1.
- With no stalls, word k appears in cycle T+1+k. Each stalled cycle adds one cycle of latency.
- DONE cycle: the cycle after the last accepted word. In it, `store_done_o`=1, `store_busy_o`=1, WEB=0.
- Next cycle: IDLE with `store_busy_o`=0. A new start is accepted in that cycle.
- N=0: `store_done_o`=1 in cycle T+1; no writes.
- Address arithmetic wraps modulo 2^32 with no error flag.

## Configuration
- `OFMAP_RELU_EN` defined: each captured byte is treated as signed, and negative values (bit7=1) are replaced by 0x00 before packing.
- Not defined: bytes are stored raw.
- Packing and timing are identical in both builds.

## Test plan
- Aligned pointwise, base 0x100, no stalls, data byte c = c+1:
  - 8 writes at 0x100..0x11C, WEB=4'hF.
  - word0 = 0x04030201.
  - `store_done_o` in cycle T+9.
- Unaligned depthwise, base 0x203, N=10 → 4 writes:
  - 0x200, WEB=4'b1000, byte0 in lane3.
  - 0x204, WEB=4'hF.
  - 0x208, WEB=4'hF.
  - 0x20C, WEB=4'b0001, byte9 in lane0.
- Stall: pointwise, `glb_stall_i`=1 for 3 cycles during word 2:
  - word 2 address/data/WEB held for 4 cycles.
  - done arrives 3 cycles later than without the stall.
- `store_start_i` pulsed mid-WRITE with a different base:
  - ignored; the original sequence completes unchanged.
  - a start in the cycle after DONE begins a new store.
- `rst_n` asserted at word 3 of a pointwise store:
  - all outputs 0 immediately; no done pulse.
  - a restart after reset produces a full 8-word sequence.
- `OFMAP_RELU_EN` build, bytes {0x80, 0x7F, 0xFF, 0x01}, base 0:
  - word0 = 0x01007F00.
  - a non-RELU build writes 0x01FF7F80.
